// File: rtl/cvxif_share_arbiter.sv
// Shares one CV-X-IF coprocessor among NumReq cores: round-robin issue,
// slot-tracked outstanding instructions, out-of-order result routing.
module cvxif_share_arbiter #(
  parameter int NumReq   = 2,
  parameter int NumSlots = 4,
  parameter int IdWidth  = 3,
  parameter int XLEN     = 64
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NumReq-1:0]           req_issue_valid_i,
  input  logic [NumReq*32-1:0]        req_issue_instr_i,
  input  logic [NumReq*IdWidth-1:0]   req_issue_id_i,
  output logic [NumReq-1:0]           req_issue_ready_o,
  output logic [NumReq-1:0]           req_issue_accept_o,
  output logic                        co_issue_valid_o,
  input  logic                        co_issue_ready_i,
  output logic [31:0]                 co_issue_instr_o,
  output logic [$clog2(NumSlots)-1:0] co_issue_id_o,
  input  logic                        co_issue_accept_i,
  input  logic                        co_result_valid_i,
  output logic                        co_result_ready_o,
  input  logic [$clog2(NumSlots)-1:0] co_result_id_i,
  input  logic [XLEN-1:0]             co_result_data_i,
  output logic [NumReq-1:0]           req_result_valid_o,
  input  logic [NumReq-1:0]           req_result_ready_i,
  output logic [IdWidth-1:0]          req_result_id_o,
  output logic [XLEN-1:0]             req_result_data_o,
  output logic [$clog2(NumSlots):0]   busy_slots_o,
  output logic                        err_o
);

  localparam int SlotW = $clog2(NumSlots);
  localparam int OwnW  = $clog2(NumReq);

  typedef enum logic {ARB, HOLD} state_e;

  state_e              state_q;
  logic [NumSlots-1:0] busy_q, busy_d;
  logic [OwnW-1:0]     own_q [NumSlots];
  logic [IdWidth-1:0]  id_q  [NumSlots];
  logic [OwnW-1:0]     rr_q, hold_gnt_q;
  logic [SlotW-1:0]    hold_slot_q;
  logic                err_q;

  logic [OwnW-1:0]     arb_gnt, gnt;
  logic [SlotW-1:0]    free_idx, slot;
  logic                free_any, arb_found;
  logic                iss_hs, iss_alloc;
  logic                res_busy, res_hs;
  logic [OwnW-1:0]     res_own;
  logic [SlotW:0]      cnt;
  int                  k;

  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int i = NumSlots - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_any = 1'b1;
        free_idx = SlotW'(i);
      end
    end
  end

  // first valid core at or after the pointer, wrapping
  always_comb begin
    arb_found = 1'b0;
    arb_gnt   = '0;
    k         = 0;
    for (int i = 0; i < NumReq; i++) begin
      k = (int'(rr_q) + i) % NumReq;
      if (!arb_found && req_issue_valid_i[k]) begin
        arb_found = 1'b1;
        arb_gnt   = OwnW'(k);
      end
    end
  end

  always_comb begin
    if (state_q == HOLD) begin
      co_issue_valid_o = 1'b1;
      gnt              = hold_gnt_q;
      slot             = hold_slot_q;
    end else begin
      co_issue_valid_o = arb_found & free_any;
      gnt              = arb_gnt;
      slot             = free_idx;
    end
  end

  assign iss_hs           = co_issue_valid_o & co_issue_ready_i;
  assign iss_alloc        = iss_hs & co_issue_accept_i;
  assign co_issue_instr_o = req_issue_instr_i[32*int'(gnt) +: 32];
  assign co_issue_id_o    = slot;

  always_comb begin
    req_issue_ready_o  = '0;
    req_issue_accept_o = '0;
    if (iss_hs) begin
      req_issue_ready_o[gnt]  = 1'b1;
      req_issue_accept_o[gnt] = co_issue_accept_i;
    end
  end

  assign res_busy = busy_q[co_result_id_i];
  assign res_own  = own_q[co_result_id_i];

  // results for free slots are sunk so the coprocessor never stalls
  always_comb begin
    req_result_valid_o = '0;
    co_result_ready_o  = co_result_valid_i;
    if (res_busy) begin
      req_result_valid_o[res_own] = co_result_valid_i;
      co_result_ready_o           = req_result_ready_i[res_own];
    end
  end

  assign res_hs            = co_result_valid_i & co_result_ready_o & res_busy;
  assign req_result_id_o   = id_q[co_result_id_i];
  assign req_result_data_o = co_result_data_i;

  always_comb begin
    busy_d = busy_q;
    if (res_hs)    busy_d[co_result_id_i] = 1'b0;
    if (iss_alloc) busy_d[slot]           = 1'b1;
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < NumSlots; i++) begin
      cnt = cnt + (SlotW+1)'(busy_q[i]);
    end
  end

  assign busy_slots_o = cnt;
  assign err_o        = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ARB;
      busy_q      <= '0;
      rr_q        <= '0;
      hold_gnt_q  <= '0;
      hold_slot_q <= '0;
      err_q       <= 1'b0;
    end else begin
      busy_q <= busy_d;
      unique case (state_q)
        ARB: begin
          if (co_issue_valid_o && !co_issue_ready_i) begin
            state_q     <= HOLD;
            hold_gnt_q  <= gnt;
            hold_slot_q <= slot;
          end
        end
        HOLD: begin
          if (co_issue_ready_i) state_q <= ARB;
        end
        default: state_q <= ARB;
      endcase
      if (iss_hs) begin
        rr_q <= (gnt == OwnW'(NumReq - 1)) ? '0 : gnt + 1'b1;
      end
      if (co_result_valid_i && !res_busy) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (iss_alloc) begin
      own_q[slot] <= gnt;
      id_q[slot]  <= req_issue_id_i[IdWidth*int'(gnt) +: IdWidth];
    end
  end

endmodule

// File: tb/tb_cvxif_share_arbiter.sv
// Scoreboard bench for cvxif_share_arbiter: models slot allocation,
// round-robin order and result routing, one task per scenario.
module tb_cvxif_share_arbiter;
  localparam int NR = 2;
  localparam int NS = 4;
  localparam int IW = 3;
  localparam int XL = 64;

  logic clk = 1'b0;
  logic rst;
  logic [NR-1:0]    req_issue_valid_i;
  logic [NR*32-1:0] req_issue_instr_i;
  logic [NR*IW-1:0] req_issue_id_i;
  logic [NR-1:0]    req_issue_ready_o, req_issue_accept_o;
  logic             co_issue_valid_o, co_issue_ready_i, co_issue_accept_i;
  logic [31:0]      co_issue_instr_o;
  logic [1:0]       co_issue_id_o;
  logic             co_result_valid_i, co_result_ready_o;
  logic [1:0]       co_result_id_i;
  logic [XL-1:0]    co_result_data_i;
  logic [NR-1:0]    req_result_valid_o, req_result_ready_i;
  logic [IW-1:0]    req_result_id_o;
  logic [XL-1:0]    req_result_data_o;
  logic [2:0]       busy_slots_o;
  logic             err_o;

  always #5 clk = ~clk;

  cvxif_share_arbiter #(.NumReq(NR), .NumSlots(NS), .IdWidth(IW), .XLEN(XL)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_issue_valid_i(req_issue_valid_i), .req_issue_instr_i(req_issue_instr_i),
    .req_issue_id_i(req_issue_id_i), .req_issue_ready_o(req_issue_ready_o),
    .req_issue_accept_o(req_issue_accept_o), .co_issue_valid_o(co_issue_valid_o),
    .co_issue_ready_i(co_issue_ready_i), .co_issue_instr_o(co_issue_instr_o),
    .co_issue_id_o(co_issue_id_o), .co_issue_accept_i(co_issue_accept_i),
    .co_result_valid_i(co_result_valid_i), .co_result_ready_o(co_result_ready_o),
    .co_result_id_i(co_result_id_i), .co_result_data_i(co_result_data_i),
    .req_result_valid_o(req_result_valid_o), .req_result_ready_i(req_result_ready_i),
    .req_result_id_o(req_result_id_o), .req_result_data_o(req_result_data_o),
    .busy_slots_o(busy_slots_o), .err_o(err_o)
  );

  typedef struct {
    logic [NR-1:0] vld;
    logic [IW-1:0] id;
    logic [XL-1:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int n_cmp = 0;
  int n_err = 0;

  bit            m_busy[NS];
  int            m_own[NS];
  logic [IW-1:0] m_id[NS];
  int            m_rr;

  function automatic int m_free();
    for (int i = 0; i < NS; i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  function automatic int m_cnt();
    int c = 0;
    for (int i = 0; i < NS; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic int m_gnt(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[(m_rr + i) % NR]) return (m_rr + i) % NR;
    return -1;
  endfunction

  function automatic logic [NR-1:0] oh(input int c);
    logic [NR-1:0] r = '0;
    r[c] = 1'b1;
    return r;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NS; i++) m_busy[i] = 1'b0;
    m_rr = 0;
  endtask

  task automatic m_hs(input int g, input bit acc, input int s);
    if (acc) begin
      m_busy[s] = 1'b1;
      m_own[s]  = g;
      m_id[s]   = req_issue_id_i[IW*g +: IW];
    end
    m_rr = (g + 1) % NR;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_core(input int c, input logic [31:0] ins, input logic [IW-1:0] id);
    req_issue_instr_i[32*c +: 32] = ins;
    req_issue_id_i[IW*c +: IW]    = id;
  endtask

  task automatic res_drive(input int s, input logic [XL-1:0] d);
    co_result_valid_i  = 1'b1;
    co_result_id_i     = 2'(s);
    co_result_data_i   = d;
    req_result_ready_i = '1;
    e.vld  = m_busy[s] ? oh(m_own[s]) : '0;
    e.id   = m_id[s];
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic clr();
    req_issue_valid_i  = '0;
    co_issue_ready_i   = 1'b0;
    co_issue_accept_i  = 1'b0;
    co_result_valid_i  = 1'b0;
    co_result_id_i     = '0;
    co_result_data_i   = '0;
    req_result_ready_i = '0;
  endtask

  task automatic test_reset();
    clr();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    m_reset();
    smp();
    n_cmp++;
    if (busy_slots_o !== 3'd0) begin
      n_err++; $display("FAIL rst_busy got %0d want 0", busy_slots_o);
    end
    n_cmp++;
    if (err_o !== 1'b0) begin
      n_err++; $display("FAIL rst_err got %b want 0", err_o);
    end
    n_cmp++;
    if ({co_issue_valid_o, co_result_ready_o, req_issue_ready_o, req_result_valid_o} !== '0) begin
      n_err++; $display("FAIL rst_outs got %b%b%b%b want 0", co_issue_valid_o,
                        co_result_ready_o, req_issue_ready_o, req_result_valid_o);
    end
    tick();
  endtask

  task automatic test_single();
    int es;
    set_core(0, 32'h0000_000B, 3'd5);
    req_issue_valid_i = 2'b01;
    co_issue_ready_i  = 1'b1;
    co_issue_accept_i = 1'b1;
    es = m_free();
    smp();
    n_cmp++;
    if (req_issue_ready_o !== 2'b01 || req_issue_accept_o !== 2'b01) begin
      n_err++; $display("FAIL t1_hs got %b/%b want 01/01", req_issue_ready_o, req_issue_accept_o);
    end
    n_cmp++;
    if (co_issue_id_o !== 2'(es) || co_issue_instr_o !== 32'h0000_000B) begin
      n_err++; $display("FAIL t1_issue got %0d/%h want %0d/0000000b", co_issue_id_o, co_issue_instr_o, es);
    end
    m_hs(0, 1'b1, es);
    tick();
    clr();
    smp();
    n_cmp++;
    if (busy_slots_o !== 3'(m_cnt())) begin
      n_err++; $display("FAIL t1_busy got %0d want %0d", busy_slots_o, m_cnt());
    end
    tick();
    res_drive(0, 64'hAB);
    smp();
    e = sb.pop_front();
    n_cmp++;
    if (req_result_valid_o !== e.vld || req_result_id_o !== e.id || req_result_data_o !== e.data) begin
      n_err++; $display("FAIL t1_res got %b/%0d/%h want %b/%0d/%h", req_result_valid_o,
                        req_result_id_o, req_result_data_o, e.vld, e.id, e.data);
    end
    m_busy[0] = 1'b0;
    tick();
    clr();
    smp();
    n_cmp++;
    if (busy_slots_o !== 3'd0) begin
      n_err++; $display("FAIL t1_free got %0d want 0", busy_slots_o);
    end
    tick();
  endtask

  task automatic test_drain();
    for (int s = 0; s < NS; s++) begin
      if (m_busy[s]) begin
        res_drive(s, 64'hD000 + 64'(s));
        smp();
        e = sb.pop_front();
        n_cmp++;
        if (req_result_valid_o !== e.vld || req_result_id_o !== e.id || req_result_data_o !== e.data) begin
          n_err++; $display("FAIL drain_s%0d got %b/%0d/%h want %b/%0d/%h", s, req_result_valid_o,
                            req_result_id_o, req_result_data_o, e.vld, e.id, e.data);
        end
        m_busy[s] = 1'b0;
        tick();
        clr();
      end
    end
  endtask

  task automatic test_back_to_back();
    int prev = -1;
    int eg, es;
    int gc[NR];
    for (int i = 0; i < NR; i++) gc[i] = 0;
    for (int c = 0; c < 8; c++) begin
      set_core(0, 32'h1000 + 32'(c), 3'(c));
      set_core(1, 32'h2000 + 32'(c), 3'(c + 3));
      req_issue_valid_i = 2'b11;
      co_issue_ready_i  = 1'b1;
      co_issue_accept_i = 1'b1;
      if (prev >= 0) res_drive(prev, 64'hC0 + 64'(c));
      eg = m_gnt(2'b11);
      es = m_free();
      smp();
      n_cmp++;
      if (req_issue_ready_o !== oh(eg) || co_issue_id_o !== 2'(es)) begin
        n_err++; $display("FAIL b2b_c%0d got %b/%0d want %b/%0d", c, req_issue_ready_o,
                          co_issue_id_o, oh(eg), es);
      end
      n_cmp++;
      if (busy_slots_o !== 3'(m_cnt())) begin
        n_err++; $display("FAIL b2b_busy_c%0d got %0d want %0d", c, busy_slots_o, m_cnt());
      end
      if (prev >= 0) begin
        e = sb.pop_front();
        n_cmp++;
        if (req_result_valid_o !== e.vld || req_result_id_o !== e.id || req_result_data_o !== e.data) begin
          n_err++; $display("FAIL b2b_res_c%0d got %b/%0d/%h want %b/%0d/%h", c, req_result_valid_o,
                            req_result_id_o, req_result_data_o, e.vld, e.id, e.data);
        end
        m_busy[prev] = 1'b0;
      end
      m_hs(eg, 1'b1, es);
      gc[eg]++;
      prev = es;
      tick();
      clr();
    end
    n_cmp++;
    if (gc[0] != 4 || gc[1] != 4) begin
      n_err++; $display("FAIL b2b_fair got %0d/%0d want 4/4", gc[0], gc[1]);
    end
    test_drain();
  endtask

  task automatic test_hold();
    int eg, es;
    set_core(0, 32'hAAAA_0000, 3'd2);
    set_core(1, 32'hBBBB_0000, 3'd7);
    req_issue_valid_i = 2'b11;
    co_issue_accept_i = 1'b1;
    eg = m_gnt(2'b11);
    es = m_free();
    for (int h = 0; h < 3; h++) begin
      smp();
      n_cmp++;
      if (co_issue_valid_o !== 1'b1 || req_issue_ready_o !== 2'b00 || co_issue_id_o !== 2'(es) ||
          co_issue_instr_o !== req_issue_instr_i[32*eg +: 32]) begin
        n_err++; $display("FAIL hold_c%0d got v%b r%b id%0d %h want v1 r00 id%0d core%0d", h,
                          co_issue_valid_o, req_issue_ready_o, co_issue_id_o, co_issue_instr_o, es, eg);
      end
      tick();
    end
    co_issue_ready_i = 1'b1;
    smp();
    n_cmp++;
    if (req_issue_ready_o !== oh(eg) || req_issue_accept_o !== oh(eg) || co_issue_id_o !== 2'(es)) begin
      n_err++; $display("FAIL hold_hs got %b/%b/%0d want %b/%b/%0d", req_issue_ready_o,
                        req_issue_accept_o, co_issue_id_o, oh(eg), oh(eg), es);
    end
    m_hs(eg, 1'b1, es);
    tick();
    clr();
    test_drain();
  endtask

  task automatic test_full();
    int es;
    co_issue_ready_i  = 1'b1;
    co_issue_accept_i = 1'b1;
    for (int k = 0; k < NS; k++) begin
      set_core(k % 2, 32'h3000 + 32'(k), 3'(k + 2));
      req_issue_valid_i = oh(k % 2);
      es = m_free();
      smp();
      n_cmp++;
      if (req_issue_ready_o !== oh(k % 2) || co_issue_id_o !== 2'(es)) begin
        n_err++; $display("FAIL full_fill%0d got %b/%0d want %b/%0d", k, req_issue_ready_o,
                          co_issue_id_o, oh(k % 2), es);
      end
      m_hs(k % 2, 1'b1, es);
      tick();
    end
    req_issue_valid_i = 2'b01;
    smp();
    n_cmp++;
    if (busy_slots_o !== 3'd4 || co_issue_valid_o !== 1'b0 || req_issue_ready_o !== 2'b00) begin
      n_err++; $display("FAIL full_stall got busy%0d v%b r%b want busy4 v0 r00", busy_slots_o,
                        co_issue_valid_o, req_issue_ready_o);
    end
    tick();
    res_drive(2, 64'h2222);
    smp();
    e = sb.pop_front();
    n_cmp++;
    if (req_result_valid_o !== e.vld || req_result_id_o !== e.id || co_issue_valid_o !== 1'b0) begin
      n_err++; $display("FAIL full_free got %b/%0d v%b want %b/%0d v0", req_result_valid_o,
                        req_result_id_o, co_issue_valid_o, e.vld, e.id);
    end
    m_busy[2] = 1'b0;
    tick();
    co_result_valid_i = 1'b0;
    es = m_free();
    smp();
    n_cmp++;
    if (co_issue_valid_o !== 1'b1 || co_issue_id_o !== 2'd2 || es != 2) begin
      n_err++; $display("FAIL full_reuse got v%b id%0d want v1 id2", co_issue_valid_o, co_issue_id_o);
    end
    m_hs(0, 1'b1, es);
    tick();
    clr();
    test_drain();
  endtask

  task automatic test_reject_ooo();
    int es;
    co_issue_ready_i  = 1'b1;
    co_issue_accept_i = 1'b1;
    for (int c = 0; c < NR; c++) begin
      set_core(c, 32'h4000 + 32'(c), (c == 0) ? 3'd1 : 3'd6);
      req_issue_valid_i = oh(c);
      es = m_free();
      m_hs(c, 1'b1, es);
      tick();
    end
    req_issue_valid_i = 2'b01;
    co_issue_accept_i = 1'b0;
    smp();
    n_cmp++;
    if (req_issue_ready_o !== 2'b01 || req_issue_accept_o !== 2'b00) begin
      n_err++; $display("FAIL rej_hs got %b/%b want 01/00", req_issue_ready_o, req_issue_accept_o);
    end
    m_hs(0, 1'b0, 0);
    tick();
    clr();
    smp();
    n_cmp++;
    if (busy_slots_o !== 3'(m_cnt())) begin
      n_err++; $display("FAIL rej_busy got %0d want %0d", busy_slots_o, m_cnt());
    end
    tick();
    co_result_valid_i  = 1'b1;
    co_result_id_i     = 2'd1;
    co_result_data_i   = 64'h11;
    req_result_ready_i = 2'b00;
    smp();
    n_cmp++;
    if (req_result_valid_o !== oh(m_own[1]) || co_result_ready_o !== 1'b0) begin
      n_err++; $display("FAIL ooo_bp got %b/%b want %b/0", req_result_valid_o, co_result_ready_o, oh(m_own[1]));
    end
    tick();
    for (int k = 1; k >= 0; k--) begin
      res_drive(k, 64'h5500 + 64'(k));
      smp();
      e = sb.pop_front();
      n_cmp++;
      if (req_result_valid_o !== e.vld || req_result_id_o !== e.id || req_result_data_o !== e.data ||
          co_result_ready_o !== 1'b1) begin
        n_err++; $display("FAIL ooo_s%0d got %b/%0d/%h want %b/%0d/%h", k, req_result_valid_o,
                          req_result_id_o, req_result_data_o, e.vld, e.id, e.data);
      end
      m_busy[k] = 1'b0;
      tick();
      clr();
    end
    smp();
    n_cmp++;
    if (busy_slots_o !== 3'd0) begin
      n_err++; $display("FAIL ooo_busy got %0d want 0", busy_slots_o);
    end
    tick();
  endtask

  task automatic test_err();
    res_drive(3, 64'hEE);
    smp();
    e = sb.pop_front();
    n_cmp++;
    if (co_result_ready_o !== 1'b1 || req_result_valid_o !== e.vld) begin
      n_err++; $display("FAIL err_sink got %b/%b want 1/%b", co_result_ready_o, req_result_valid_o, e.vld);
    end
    tick();
    clr();
    repeat (3) tick();
    smp();
    n_cmp++;
    if (err_o !== 1'b1) begin
      n_err++; $display("FAIL err_sticky got %b want 1", err_o);
    end
    tick();
    test_reset();
    set_core(0, 32'h0000_00FF, 3'd4);
    req_issue_valid_i = 2'b01;
    co_issue_ready_i  = 1'b1;
    co_issue_accept_i = 1'b1;
    tick();
    clr();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_reset();
    smp();
    n_cmp++;
    if (busy_slots_o !== 3'd0 || err_o !== 1'b0) begin
      n_err++; $display("FAIL midrst got busy%0d err%b want 0/0", busy_slots_o, err_o);
    end
    tick();
    res_drive(0, 64'h77);
    smp();
    e = sb.pop_front();
    n_cmp++;
    if (req_result_valid_o !== e.vld || co_result_ready_o !== 1'b1) begin
      n_err++; $display("FAIL late_res got %b/%b want %b/1", req_result_valid_o, co_result_ready_o, e.vld);
    end
    tick();
    clr();
    smp();
    n_cmp++;
    if (err_o !== 1'b1) begin
      n_err++; $display("FAIL late_err got %b want 1", err_o);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    req_issue_instr_i = '0;
    req_issue_id_i    = '0;
    clr();
    m_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_hold();
    test_full();
    test_reject_ooo();
    test_err();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
